// File: rtl/i2c_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter_pkg
// Shared definitions for the I2C bus arbiter: FSM state encoding, the CLCD
// backpack slave address and a helper that sizes the round-robin pointer.
// -----------------------------------------------------------------------------
package i2c_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GRANT     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_XFER      = 2'd3
  } state_t;

  // PCF8574 backpack driving the character LCD
  localparam logic [6:0] CLCD_SLAVE_ADDR = 7'h27;

  // Width of a client index / round-robin pointer (at least one bit)
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping around, as a one-hot vector plus its index.
//
// Ports
//   req       in   N_REQ  request vector (already masked by the caller)
//   ptr       in   PW     client with highest priority this cycle
//   pick      out  N_REQ  one-hot selected client, 0 when req == 0
//   pick_idx  out  PW     index of the selected client (0 when none)
// -----------------------------------------------------------------------------
module rr_select
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [PW-1:0]    pick_idx
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        pick_idx  = idx;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter
// Shares one I2C master between N_REQ client sequencers. A grant is locked for
// as long as the client holds i_req, so multi-byte sequences (nibble/EN
// writes, address read-back, line change) go out uninterrupted. Arbitration is
// round-robin; a watchdog reclaims a grant that sees no new transaction for
// TIMEOUT_CYC cycles, and the offending client must drop i_req before it can
// be granted again.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   i_req      [N]        per-client request, held for the whole sequence
//   i_addr     [7N]       per-client slave address, client k at [7k+:7]
//   i_data     [8N]       per-client write byte
//   i_RW       [N]        per-client direction, 1 = read
//   i_valid    [N]        per-client one-cycle transaction strobe
//   o_grant    [N]        one-hot grant
//   o_busy     [N]        master busy routed to the granted client
//   o_done     [N]        one-cycle pulse when the client's transfer ends
//   o_rdata    [8N]       per-client last read byte
//   o_timeout             one-cycle pulse on a watchdog release
//   o_addr/o_data/o_RW    transaction to the master
//   o_valid               request to the master, held until busy rises
//   i_busy, i_receive     master status and read byte
// -----------------------------------------------------------------------------
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int          N_REQ       = 2,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int          CW          = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [7*N_REQ-1:0] i_addr,
  input  logic [8*N_REQ-1:0] i_data,
  input  logic [N_REQ-1:0]   i_RW,
  input  logic [N_REQ-1:0]   i_valid,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_busy,
  output logic [N_REQ-1:0]   o_done,
  output logic [8*N_REQ-1:0] o_rdata,
  output logic               o_timeout,
  output logic [6:0]         o_addr,
  output logic [7:0]         o_data,
  output logic               o_RW,
  output logic               o_valid,
  input  logic               i_busy,
  input  logic [7:0]         i_receive
);

  localparam int            PW      = ptr_w(N_REQ);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);

  state_t                  state;
  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           gidx;
  logic [PW-1:0]           next_ptr;
  logic [CW-1:0]           wd;
  logic                    busy_d;
  logic                    pedge;
  logic                    nedge;
  logic [N_REQ-1:0]        blocked;
  logic [N_REQ-1:0]        eligible;
  logic [N_REQ-1:0]        pick;
  logic [PW-1:0]           pick_idx;
  logic [N_REQ-1:0][6:0]   addr_v;
  logic [N_REQ-1:0][7:0]   data_v;
  logic [N_REQ-1:0][7:0]   rdata_q;

  // Per-client views of the flat buses
  assign addr_v  = i_addr;
  assign data_v  = i_data;
  assign o_rdata = rdata_q;

  assign o_busy  = o_grant & {N_REQ{i_busy}};

  // A client released by the watchdog stays out until it drops its request
  assign eligible = i_req & ~blocked;

  assign next_ptr = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  rr_select #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_select (
    .req      (eligible),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // ---- master busy edge detector ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_d <= 1'b0;
    end else begin
      busy_d <= i_busy;
    end
  end

  assign pedge = i_busy & ~busy_d;
  assign nedge = ~i_busy & busy_d;

  // ---- arbitration / forwarding FSM ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      wd        <= '0;
      blocked   <= '0;
      o_grant   <= '0;
      o_done    <= '0;
      o_timeout <= 1'b0;
      o_addr    <= '0;
      o_data    <= '0;
      o_RW      <= 1'b0;
      o_valid   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      o_done    <= '0;
      o_timeout <= 1'b0;
      blocked   <= blocked & i_req;

      case (state)
        S_IDLE: begin
          // Never hand out the bus while the master is still finishing
          // something (e.g. a transfer interrupted by reset).
          if (|eligible && !i_busy) begin
            o_grant <= pick;
            gidx    <= pick_idx;
            wd      <= '0;
            state   <= S_GRANT;
          end
        end

        S_GRANT: begin
          // A valid wins over a simultaneous req drop; the drop is seen
          // again here after the transfer completes.
          if (i_valid[gidx]) begin
            o_addr  <= addr_v[gidx];
            o_data  <= data_v[gidx];
            o_RW    <= i_RW[gidx];
            o_valid <= 1'b1;
            wd      <= '0;
            state   <= S_WAIT_BUSY;
          end else if (!i_req[gidx]) begin
            o_grant <= '0;
            rr_ptr  <= next_ptr;
            wd      <= '0;
            state   <= S_IDLE;
          end else if (wd == WD_LAST) begin
            o_grant       <= '0;
            rr_ptr        <= next_ptr;
            wd            <= '0;
            o_timeout     <= 1'b1;
            blocked[gidx] <= 1'b1;
            state         <= S_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        S_WAIT_BUSY: begin
          if (pedge) begin
            o_valid <= 1'b0;
            state   <= S_XFER;
          end
        end

        S_XFER: begin
          if (nedge) begin
            if (o_RW) begin
              rdata_q[gidx] <= i_receive;
            end
            o_done <= o_grant;
            state  <= S_GRANT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;

  localparam int N_REQ = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    i_req;
  logic [13:0]   i_addr;
  logic [15:0]   i_data;
  logic [1:0]    i_RW;
  logic [1:0]    i_valid;
  logic [1:0]    o_grant;
  logic [1:0]    o_busy;
  logic [1:0]    o_done;
  logic [15:0]   o_rdata;
  logic          o_timeout;
  logic [6:0]    o_addr;
  logic [7:0]    o_data;
  logic          o_RW;
  logic          o_valid;
  logic          i_busy;
  logic [7:0]    i_receive;

  int n_cmp = 0;
  int n_err = 0;

  i2c_bus_arbiter #(
    .N_REQ       (N_REQ),
    .TIMEOUT_CYC (16),
    .CW          (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_RW      (i_RW),
    .i_valid   (i_valid),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_rdata   (o_rdata),
    .o_timeout (o_timeout),
    .o_addr    (o_addr),
    .o_data    (o_data),
    .o_RW      (o_RW),
    .o_valid   (o_valid),
    .i_busy    (i_busy),
    .i_receive (i_receive)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  valid;
    logic [1:0]  rw;
    logic [7:0]  d0;
    logic        busy;
    logic [7:0]  recv;
    logic [1:0]  e_grant;
    logic        e_valid;
    logic [1:0]  e_busy;
    logic [1:0]  e_done;
    logic        e_rw;
    logic [7:0]  e_data;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vec [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] valid,
                       input logic [1:0] rw, input logic [7:0] d0, input logic busy);
    i_req   = req;
    i_valid = valid;
    i_RW    = rw;
    i_data  = {8'hC3, d0};
    i_busy  = busy;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 8'h00, 1'b0);
    i_receive = 8'h00;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    //            req    valid  rw     d0     bsy   recv   | grant  vld   busy   done   rw    data   rdata
    vec[0]  = '{2'b01, 2'b00, 2'b00, 8'h00, 1'b0, 8'h00,  2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 16'h0000};
    vec[1]  = '{2'b01, 2'b01, 2'b00, 8'h3D, 1'b0, 8'h00,  2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 8'h3D, 16'h0000};
    vec[2]  = '{2'b01, 2'b00, 2'b00, 8'h3D, 1'b0, 8'h00,  2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 8'h3D, 16'h0000};
    vec[3]  = '{2'b01, 2'b00, 2'b00, 8'h3D, 1'b1, 8'h00,  2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 8'h3D, 16'h0000};
    vec[4]  = '{2'b01, 2'b00, 2'b00, 8'h3D, 1'b1, 8'h00,  2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 8'h3D, 16'h0000};
    vec[5]  = '{2'b01, 2'b00, 2'b00, 8'h3D, 1'b0, 8'h00,  2'b01, 1'b0, 2'b00, 2'b01, 1'b0, 8'h3D, 16'h0000};
    vec[6]  = '{2'b00, 2'b00, 2'b00, 8'h3D, 1'b0, 8'h00,  2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h3D, 16'h0000};
    vec[7]  = '{2'b01, 2'b00, 2'b00, 8'h3D, 1'b0, 8'h00,  2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 8'h3D, 16'h0000};
    vec[8]  = '{2'b01, 2'b01, 2'b01, 8'h0F, 1'b0, 8'h00,  2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 8'h0F, 16'h0000};
    vec[9]  = '{2'b01, 2'b00, 2'b01, 8'h0F, 1'b1, 8'h00,  2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 8'h0F, 16'h0000};
    vec[10] = '{2'b01, 2'b00, 2'b01, 8'h0F, 1'b1, 8'hA5,  2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 8'h0F, 16'h0000};
    vec[11] = '{2'b01, 2'b00, 2'b01, 8'h0F, 1'b0, 8'hA5,  2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 8'h0F, 16'h00A5};
    vec[12] = '{2'b00, 2'b00, 2'b01, 8'h0F, 1'b0, 8'h00,  2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 8'h0F, 16'h00A5};

    i_addr = {7'h11, 7'h27};
    do_reset();

    // Reset state
    check("rst_grant",   o_grant,   2'b00);
    check("rst_valid",   o_valid,   1'b0);
    check("rst_done",    o_done,    2'b00);
    check("rst_timeout", o_timeout, 1'b0);
    check("rst_rdata",   o_rdata,   16'h0000);
    check("rst_addr",    o_addr,    7'h00);

    // Single client write followed by a read-back
    for (int i = 0; i < 13; i++) begin
      drive(vec[i].req, vec[i].valid, vec[i].rw, vec[i].d0, vec[i].busy);
      i_receive = vec[i].recv;
      tick();
      check($sformatf("v%0d_grant", i), o_grant,   vec[i].e_grant);
      check($sformatf("v%0d_valid", i), o_valid,   vec[i].e_valid);
      check($sformatf("v%0d_busy", i),  o_busy,    vec[i].e_busy);
      check($sformatf("v%0d_done", i),  o_done,    vec[i].e_done);
      check($sformatf("v%0d_rw", i),    o_RW,      vec[i].e_rw);
      check($sformatf("v%0d_data", i),  o_data,    vec[i].e_data);
      check($sformatf("v%0d_rdata", i), o_rdata,   vec[i].e_rdata);
      check($sformatf("v%0d_tmo", i),   o_timeout, 1'b0);
      if (i == 1) check("v1_addr", o_addr, 7'h27);
    end

    // Asynchronous reset while a request is outstanding at the master
    drive(2'b01, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("ar_grant", o_grant, 2'b01);
    drive(2'b01, 2'b01, 2'b00, 8'h3D, 1'b0);
    tick();
    check("ar_valid_before", o_valid, 1'b1);
    drive(2'b01, 2'b00, 2'b00, 8'h3D, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid",   o_valid, 1'b0);
    check("ar_grant0",  o_grant, 2'b00);
    check("ar_busy",    o_busy,  2'b00);
    check("ar_rdata",   o_rdata, 16'h0000);
    check("ar_data",    o_data,  8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    check("ar_blk1", o_grant, 2'b00);
    tick();
    check("ar_blk2", o_grant, 2'b00);
    drive(2'b01, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("ar_regrant", o_grant, 2'b01);

    // Contention and round-robin order
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("ct_first", o_grant, 2'b01);
    drive(2'b10, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("ct_rel0", o_grant, 2'b00);
    drive(2'b11, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("ct_second", o_grant, 2'b10);
    drive(2'b01, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("ct_rel1", o_grant, 2'b00);
    drive(2'b11, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("ct_third", o_grant, 2'b01);

    // Locking: client1 strobes while client0 is mid-transfer
    drive(2'b11, 2'b01, 2'b00, 8'h3D, 1'b0);
    tick();
    check("lk_valid", o_valid, 1'b1);
    drive(2'b11, 2'b00, 2'b00, 8'h3D, 1'b1);
    tick();
    check("lk_xfer", o_valid, 1'b0);
    drive(2'b11, 2'b10, 2'b10, 8'h3D, 1'b1);
    tick();
    check("lk_grant", o_grant, 2'b01);
    check("lk_busy",  o_busy,  2'b01);
    check("lk_addr",  o_addr,  7'h27);
    check("lk_data",  o_data,  8'h3D);
    check("lk_vld",   o_valid, 1'b0);
    drive(2'b11, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("lk_done", o_done, 2'b01);
    drive(2'b10, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("lk_rel", o_grant, 2'b00);
    tick();
    check("lk_next", o_grant, 2'b10);
    check("lk_data_kept", o_data, 8'h3D);

    // Watchdog release after 16 idle cycles
    drive(2'b00, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("wd_idle", o_grant, 2'b00);
    drive(2'b11, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("wd_grant", o_grant, 2'b01);
    for (int c = 1; c <= 15; c++) begin
      tick();
      check($sformatf("wd_c%0d_tmo", c), o_timeout, 1'b0);
    end
    check("wd_hold", o_grant, 2'b01);
    tick();
    check("wd_pulse", o_timeout, 1'b1);
    check("wd_rel",   o_grant,   2'b00);
    tick();
    check("wd_pulse_end", o_timeout, 1'b0);
    check("wd_next",      o_grant,   2'b10);
    drive(2'b01, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("wd_rel1", o_grant, 2'b00);
    tick();
    check("wd_locked_out", o_grant, 2'b00);
    drive(2'b00, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    drive(2'b01, 2'b00, 2'b00, 8'h3D, 1'b0);
    tick();
    check("wd_rereq", o_grant, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
